// File: rtl/ps2_key_ctrl.sv
// PS/2 Set-2 scan-code sequencer: folds E0/F0/E1 prefixes into single key events
// and queues them in a small FIFO with a valid/ready consumer interface.
module ps2_key_ctrl #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_ext,
    output logic                     ev_break,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic                     err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     pcnt_q, pcnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           push;
    logic [9:0]     push_w;
    logic           filt, pfx_ext, pfx_brk;

    assign filt    = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign pfx_ext = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    assign pfx_brk = (state_q == GOT_F0) || (state_q == GOT_E0F0);

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        push    = 1'b0;
        push_w  = '0;
        if (byte_valid) begin
            tmo_d = '0;
            if (state_q == PAUSE) begin
                // Pause bytes are consumed blindly; only the count matters.
                pcnt_d = pcnt_q - 3'd1;
                if (pcnt_q == 3'd1) begin
                    push    = 1'b1;
                    push_w  = {8'hE1, 1'b1, 1'b0};
                    state_d = IDLE;
                end
            end else if (byte_in == 8'hE0) begin
                state_d = GOT_E0;
            end else if (byte_in == 8'hF0) begin
                state_d = pfx_ext ? GOT_E0F0 : GOT_F0;
            end else if (byte_in == 8'hE1) begin
                state_d = PAUSE;
                pcnt_d  = 3'd7;
            end else if (filt) begin
                state_d = IDLE;
            end else begin
                push    = 1'b1;
                push_w  = {byte_in, pfx_ext, pfx_brk};
                state_d = IDLE;
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                pcnt_d  = '0;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign err_timeout = err_q;

    logic [9:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, count;
    logic        empty, full, pop, wr_en, drop, ovf_q;

    assign count = wr_q - rd_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = !empty && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= push_w;
    end

    logic [9:0] head;
    assign head     = empty ? 10'd0 : mem_q[rd_q[AW-1:0]];
    assign ev_code  = head[9:2];
    assign ev_ext   = head[1];
    assign ev_break = head[0];
    assign ev_valid = !empty;
    assign ev_count = count;
    assign overflow = ovf_q;
endmodule
